// File: rtl/clock_step_ctrl_pkg.sv
// Shared definitions for the CPU clock-step controller.
// Holds the mode encodings driven on the state output, the board prescale
// constant used by the clock divider that feeds tick_lvl, and a small helper
// for breakpoint qualification.
// Optional feature macro used by the top: CLOCK_STEP_CYCLE_COUNT_EN.
package clock_step_ctrl_pkg;

  // Divider ratio between clk and the CPU clock level (tick_lvl period in clk).
  localparam int CSC_PRESCALE = 10;

  // Debug modes; the numeric values are visible to software on the state port.
  typedef enum logic [1:0] {
    CSC_HALTED = 2'd0,
    CSC_RUN    = 2'd1,
    CSC_STEP   = 2'd2,
    CSC_BREAK  = 2'd3
  } csc_state_e;

  // A breakpoint stops the CPU unless we have just been released from it and
  // have not yet let the CPU move past the breakpoint address.
  function automatic logic csc_brk_hit(input logic brk, input logic skip_brk);
    return brk & ~skip_brk;
  endfunction

endpackage

// File: rtl/clock_step_ctrl_edge.sv
// Single-flop rising-edge detector for a level that is already synchronous
// to clk. The delayed copy resets to RST_VAL so that a level already high when
// reset is released is not mistaken for an edge.
module edge_rise_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_lvl,
  output logic o_rise
);

  logic r_lvl_q;

  // Previous-cycle copy of the level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lvl_q <= RST_VAL;
    end else begin
      r_lvl_q <= i_lvl;
    end
  end

  assign o_rise = i_lvl & ~r_lvl_q;

endmodule

// File: rtl/clock_step_ctrl.sv
// CPU clock-step controller.
// Turns rising edges of the divided CPU clock level into one-clk CPU enables
// and gates them by debug mode: free run, halted, step N cycles, or stopped
// at a breakpoint. Enables and step_done are registered (1 clk after the tick).
// Optional feature: define CLOCK_STEP_CYCLE_COUNT_EN to add the cycle_cnt
// output counting every issued enable (CYC_W bits, wrapping).
module clock_step_ctrl
  import clock_step_ctrl_pkg::*;
#(
  parameter int STEP_W = 16
`ifdef CLOCK_STEP_CYCLE_COUNT_EN
  ,
  parameter int CYC_W  = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_lvl,
  input  logic              run,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic [STEP_W-1:0] step_n,
  input  logic              brk,
  input  logic              brk_clr,
  output logic              cpu_en,
  output logic [1:0]        state,
  output logic              step_done
`ifdef CLOCK_STEP_CYCLE_COUNT_EN
  ,
  output logic [CYC_W-1:0]  cycle_cnt
`endif
);

  logic              w_tick;
  logic              w_brk_hit;

  csc_state_e        r_state;
  csc_state_e        w_state_nxt;
  logic [STEP_W-1:0] r_remaining;
  logic [STEP_W-1:0] w_remaining_nxt;
  logic              r_skip_brk;
  logic              w_skip_brk_nxt;
  logic              r_cpu_en;
  logic              w_cpu_en_nxt;
  logic              r_step_done;
  logic              w_step_done_nxt;

  // One-clk tick per 0->1 of the divided clock level.
  edge_rise_det #(
    .RST_VAL (1'b1)
  ) u_tick_det (
    .clk    (clk),
    .reset  (reset),
    .i_lvl  (tick_lvl),
    .o_rise (w_tick)
  );

  assign w_brk_hit = csc_brk_hit(brk, r_skip_brk);

  // Mode register plus the registered enable/done pulses and step bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= CSC_HALTED;
      r_remaining <= '0;
      r_skip_brk  <= 1'b0;
      r_cpu_en    <= 1'b0;
      r_step_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_skip_brk  <= w_skip_brk_nxt;
      r_cpu_en    <= w_cpu_en_nxt;
      r_step_done <= w_step_done_nxt;
    end
  end

  // Next mode and pulse decisions. Priority inside a mode:
  // halt/run-drop first, then breakpoint, then the normal tick action.
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_skip_brk_nxt  = r_skip_brk;
    w_cpu_en_nxt    = 1'b0;
    w_step_done_nxt = 1'b0;

    case (r_state)
      CSC_HALTED: begin
        // Free run wins over a simultaneous step request.
        if (run) begin
          w_state_nxt = CSC_RUN;
        end else if (step_req) begin
          if (step_n != '0) begin
            w_state_nxt     = CSC_STEP;
            w_remaining_nxt = step_n;
          end else begin
            // Empty burst: report completion without touching the CPU.
            w_step_done_nxt = 1'b1;
          end
        end
      end

      CSC_RUN: begin
        if (!run || halt_req) begin
          // A tick arriving in this clk is dropped.
          w_state_nxt = CSC_HALTED;
        end else if (w_tick) begin
          if (w_brk_hit) begin
            w_state_nxt = CSC_BREAK;
          end else begin
            w_cpu_en_nxt   = 1'b1;
            w_skip_brk_nxt = 1'b0;
          end
        end
      end

      CSC_STEP: begin
        if (halt_req) begin
          // Abort: burst ends early but still reports completion.
          w_state_nxt     = CSC_HALTED;
          w_step_done_nxt = 1'b1;
          w_remaining_nxt = '0;
        end else if (w_tick) begin
          if (w_brk_hit) begin
            // Burst discarded silently; the break state tells the story.
            w_state_nxt     = CSC_BREAK;
            w_remaining_nxt = '0;
          end else begin
            w_cpu_en_nxt    = 1'b1;
            w_skip_brk_nxt  = 1'b0;
            w_remaining_nxt = r_remaining - STEP_W'(1);
            if (r_remaining == STEP_W'(1)) begin
              // step_done coincides with the last enable of the burst.
              w_state_nxt     = CSC_HALTED;
              w_step_done_nxt = 1'b1;
            end
          end
        end
      end

      CSC_BREAK: begin
        // Leaving the breakpoint arms a one-shot skip so the CPU can step
        // off the breakpoint address even while brk is still asserted.
        if (brk_clr) begin
          w_state_nxt    = CSC_HALTED;
          w_skip_brk_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = CSC_HALTED;
      end
    endcase
  end

  assign cpu_en    = r_cpu_en;
  assign state     = r_state;
  assign step_done = r_step_done;

`ifdef CLOCK_STEP_CYCLE_COUNT_EN
  logic [CYC_W-1:0] r_cycle_cnt;

  // Running count of enables handed to the CPU; wraps, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle_cnt <= '0;
    end else if (w_cpu_en_nxt) begin
      r_cycle_cnt <= r_cycle_cnt + CYC_W'(1);
    end
  end

  assign cycle_cnt = r_cycle_cnt;
`endif

endmodule

// File: tb/tb_clock_step_ctrl.sv
// Directed bench for clock_step_ctrl with an event scoreboard.
// Expected cpu_en/step_done events are queued as stimulus is driven and
// popped by a monitor on the falling edge. Build with
// CLOCK_STEP_CYCLE_COUNT_EN defined to also cover cycle_cnt (CYC_W=4).
module tb_clock_step_ctrl;

  localparam int STEP_W = 16;
  localparam int TICK_P = 10;

  logic              clk      = 1'b0;
  logic              reset    = 1'b1;
  logic              tick_lvl = 1'b0;
  logic              run      = 1'b0;
  logic              halt_req = 1'b0;
  logic              step_req = 1'b0;
  logic [STEP_W-1:0] step_n   = '0;
  logic              brk      = 1'b0;
  logic              brk_clr  = 1'b0;
  logic              cpu_en;
  logic [1:0]        state;
  logic              step_done;
`ifdef CLOCK_STEP_CYCLE_COUNT_EN
  localparam int CYC_W = 4;
  logic [CYC_W-1:0]  cycle_cnt;
`endif

  typedef struct {
    int   cyc;
    logic en;
    logic done;
  } evt_t;

  evt_t sb[$];
  evt_t mon_e;
  int   cyc          = 0;
  int   ph           = 7;
  int   en_budget    = 0;
  int   en_total     = 0;
  int   errors       = 0;
  int   checks       = 0;
  logic done_on_last = 1'b0;
  logic lvl_prev     = 1'b1;

  always #5 clk = ~clk;

  clock_step_ctrl #(
    .STEP_W (STEP_W)
`ifdef CLOCK_STEP_CYCLE_COUNT_EN
    ,
    .CYC_W  (CYC_W)
`endif
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .tick_lvl  (tick_lvl),
    .run       (run),
    .halt_req  (halt_req),
    .step_req  (step_req),
    .step_n    (step_n),
    .brk       (brk),
    .brk_clr   (brk_clr),
    .cpu_en    (cpu_en),
    .state     (state),
    .step_done (step_done)
`ifdef CLOCK_STEP_CYCLE_COUNT_EN
    ,
    .cycle_cnt (cycle_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clk: the DUT samples at the posedge; a rising tick_lvl seen there is
  // expected to give an enable this cycle while the enable budget lasts.
  task automatic clk1();
    logic was_tick;
    was_tick = tick_lvl & ~lvl_prev;
    @(posedge clk);
    cyc++;
    if (was_tick && en_budget > 0) begin
      sb.push_back('{cyc, 1'b1, (done_on_last && en_budget == 1)});
      en_budget--;
    end
    #1;
    lvl_prev = reset ? 1'b1 : tick_lvl;
    ph       = (ph + 1) % TICK_P;
    tick_lvl = (ph < TICK_P / 2);
  endtask

  // Advance until the tick phase reaches p (ph==0 means the next posedge ticks).
  task automatic align(input int p);
    while (ph != p) clk1();
  endtask

  task automatic wait_en(input int base, input int n);
    for (int i = 0; i < 60; i++) begin
      if (en_total - base >= n) break;
      clk1();
    end
  endtask

  // Scoreboard monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (!reset && (cpu_en === 1'b1 || step_done === 1'b1)) begin
      if (cpu_en === 1'b1) en_total++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_out observed en=%0b done=%0b cyc=%0d expected=no output",
               cpu_en, step_done, cyc);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("evt_cycle", cyc, mon_e.cyc);
        chk("evt_en", cpu_en, mon_e.en);
        chk("evt_done", step_done, mon_e.done);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base;

    // Reset held across a tick_lvl rise; released with tick_lvl high.
    repeat (5) clk1();
    chk("rst_state", state, 2'd0);
    chk("rst_cpu_en", cpu_en, 1'b0);
    chk("rst_step_done", step_done, 1'b0);
`ifdef CLOCK_STEP_CYCLE_COUNT_EN
    chk("rst_cycle_cnt", cycle_cnt, 0);
`endif
    reset     = 1'b0;
    run       = 1'b1;
    en_budget = 1000;

    // Free run for 100 clk: one enable per tick.
    repeat (100) clk1();
    chk("run_state", state, 2'd1);
    run       = 1'b0;
    en_budget = 0;
    clk1();
    chk("run_drop_state", state, 2'd0);
    repeat (30) clk1();
    chk("run_en_count", en_total, 10);

    // Step burst of 3.
    align(3);
    base         = en_total;
    step_n       = 16'd3;
    step_req     = 1'b1;
    en_budget    = 3;
    done_on_last = 1'b1;
    clk1();
    step_req = 1'b0;
    chk("step3_state", state, 2'd2);
    repeat (35) clk1();
    done_on_last = 1'b0;
    chk("step3_count", en_total - base, 3);
    chk("step3_end_state", state, 2'd0);
    chk("step3_sb_empty", sb.size(), 0);

    // Empty step burst: done one clk later, no enable.
    align(3);
    base     = en_total;
    step_n   = 16'd0;
    step_req = 1'b1;
    sb.push_back('{cyc + 1, 1'b0, 1'b1});
    clk1();
    step_req = 1'b0;
    repeat (25) clk1();
    chk("step0_state", state, 2'd0);
    chk("step0_count", en_total - base, 0);
    chk("step0_sb_empty", sb.size(), 0);

    // Breakpoint before the 5th tick in free run.
    align(3);
    base      = en_total;
    run       = 1'b1;
    en_budget = 4;
    wait_en(base, 4);
    chk("brk_pre_count", en_total - base, 4);
    chk("brk_run_state", state, 2'd1);
    brk = 1'b1;
    repeat (12) clk1();
    chk("brk_state", state, 2'd3);
    chk("brk_count", en_total - base, 4);

    // Clear with brk still high: one enable escapes, then break again.
    align(3);
    brk_clr   = 1'b1;
    en_budget = 1;
    clk1();
    brk_clr = 1'b0;
    chk("brkclr_state", state, 2'd0);
    clk1();
    chk("brkclr_run_state", state, 2'd1);
    base = en_total;
    wait_en(base, 1);
    chk("skip_en_count", en_total - base, 1);
    repeat (12) clk1();
    chk("rebrk_state", state, 2'd3);
    chk("rebrk_count", en_total - base, 1);
    run     = 1'b0;
    brk     = 1'b0;
    brk_clr = 1'b1;
    clk1();
    brk_clr = 1'b0;
    clk1();
    chk("brk_exit_state", state, 2'd0);

    // Long burst aborted by halt_req arriving on a tick clk.
    align(3);
    base      = en_total;
    step_n    = 16'd1000;
    step_req  = 1'b1;
    en_budget = 2;
    clk1();
    step_req = 1'b0;
    wait_en(base, 2);
    chk("halt_pre_count", en_total - base, 2);
    chk("halt_step_state", state, 2'd2);
    align(0);
    halt_req = 1'b1;
    sb.push_back('{cyc + 1, 1'b0, 1'b1});
    clk1();
    halt_req = 1'b0;
    chk("halt_state", state, 2'd0);
    repeat (15) clk1();
    chk("halt_count", en_total - base, 2);
    chk("halt_sb_empty", sb.size(), 0);

    // run beats step_req; brk_clr outside BREAK does nothing.
    align(3);
    run      = 1'b1;
    step_req = 1'b1;
    step_n   = 16'd5;
    clk1();
    step_req = 1'b0;
    chk("run_beats_step", state, 2'd1);
    run = 1'b0;
    clk1();
    chk("run_beats_step_drop", state, 2'd0);
    brk_clr = 1'b1;
    clk1();
    brk_clr = 1'b0;
    chk("brkclr_ignored", state, 2'd0);

`ifdef CLOCK_STEP_CYCLE_COUNT_EN
    chk("cycle_cnt_wrap", cycle_cnt, en_total % 16);
`endif

    // Async reset while an enable is on the output.
    align(3);
    step_n       = 16'd10;
    step_req     = 1'b1;
    en_budget    = 10;
    done_on_last = 1'b1;
    clk1();
    step_req = 1'b0;
    align(0);
    clk1();
    chk("pre_rst_cpu_en", cpu_en, 1'b1);
    chk("pre_rst_state", state, 2'd2);
    reset = 1'b1;
    #1;
    chk("async_rst_cpu_en", cpu_en, 1'b0);
    chk("async_rst_state", state, 2'd0);
    chk("async_rst_done", step_done, 1'b0);
`ifdef CLOCK_STEP_CYCLE_COUNT_EN
    chk("async_rst_cycle_cnt", cycle_cnt, 0);
`endif
    sb.delete();
    en_budget    = 0;
    done_on_last = 1'b0;
    repeat (3) clk1();
    reset = 1'b0;
    repeat (3) clk1();
    chk("post_rst_state", state, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
